// File: rtl/exception_ctrl_if.sv
// rtl/exception_ctrl_if.sv - M-stage, CP0 and PC/hazard signal bundle for exception_ctrl
interface exception_ctrl_if;
  logic        m_valid;
  logic [31:0] m_pc;
  logic        m_in_delayslot;
  logic        m_adel_if;
  logic        m_ri;
  logic        m_ov;
  logic        m_sys;
  logic        m_bp;
  logic        m_adel_d;
  logic        m_ades_d;
  logic [31:0] m_data_addr;
  logic        m_eret;
  logic        mem_busy;
  logic [5:0]  ext_int;
  logic        timer_interrupt;
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;
  logic        cp0_en;
  logic [4:0]  cp0_except_type;
  logic [31:0] cp0_pc;
  logic        cp0_in_delayslot;
  logic [31:0] cp0_badvaddr;
  logic [5:0]  hw_ip;
  logic        stall_o;
  logic        flush_o;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output m_valid, m_pc, m_in_delayslot, m_adel_if, m_ri, m_ov, m_sys, m_bp,
           m_adel_d, m_ades_d, m_data_addr, m_eret, mem_busy, ext_int,
           timer_interrupt, cp0_status, cp0_cause, cp0_epc,
    input  cp0_en, cp0_except_type, cp0_pc, cp0_in_delayslot, cp0_badvaddr,
           hw_ip, stall_o, flush_o, redirect_valid, redirect_pc
  );

  modport slave (
    input  m_valid, m_pc, m_in_delayslot, m_adel_if, m_ri, m_ov, m_sys, m_bp,
           m_adel_d, m_ades_d, m_data_addr, m_eret, mem_busy, ext_int,
           timer_interrupt, cp0_status, cp0_cause, cp0_epc,
    output cp0_en, cp0_except_type, cp0_pc, cp0_in_delayslot, cp0_badvaddr,
           hw_ip, stall_o, flush_o, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/exception_ctrl.sv
// rtl/exception_ctrl.sv - CP0 exception/interrupt/ERET sequencer with drain, commit and flush
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [4:0]  EXC_NONE   = 5'b11111
) (
  input logic             clk,
  input logic             rst,
  exception_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT, FLUSH} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  sync1;
  logic [5:0]  sync2;
  logic [5:0]  hw_ip;
  logic        int_pend;
  logic        evt_hit;
  logic [4:0]  evt_code;
  logic [31:0] evt_bad;
  logic        accept;
  logic [4:0]  lat_type;
  logic [31:0] lat_pc;
  logic [31:0] lat_bad;
  logic        lat_ds;
  logic        stall;
  logic        flush;
  logic        commit;
  logic        redirect;
  logic [31:0] redirect_addr;

  // two-flop synchronizer for the asynchronous interrupt lines
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.ext_int;
      sync2 <= sync1;
    end
  end

  // the timer shares the top hardware interrupt line with ext_int[5]
  assign hw_ip    = {sync2[5] | bus.timer_interrupt, sync2[4:0]};
  assign int_pend = (|((bus.cp0_cause[15:8] | {hw_ip, 2'b00}) & bus.cp0_status[15:8]))
                    & bus.cp0_status[0] & ~bus.cp0_status[1];

  // priority pick of the highest-ranked event on the M-stage instruction
  always_comb begin
    evt_hit  = 1'b1;
    evt_code = EXC_NONE;
    evt_bad  = '0;
    if (int_pend) begin
      evt_code = 5'h00;
    end else if (bus.m_adel_if) begin
      evt_code = 5'h04;
      evt_bad  = bus.m_pc;
    end else if (bus.m_ri) begin
      evt_code = 5'h0A;
    end else if (bus.m_ov) begin
      evt_code = 5'h0C;
    end else if (bus.m_sys) begin
      evt_code = 5'h08;
    end else if (bus.m_bp) begin
      evt_code = 5'h09;
    end else if (bus.m_adel_d) begin
      evt_code = 5'h04;
      evt_bad  = bus.m_data_addr;
    end else if (bus.m_ades_d) begin
      evt_code = 5'h05;
      evt_bad  = bus.m_data_addr;
    end else if (bus.m_eret) begin
      evt_code = EXC_NONE;
    end else begin
      evt_hit = 1'b0;
    end
  end

  assign accept = (state == IDLE) && bus.m_valid && evt_hit;

  // capture the accepted event; the values stay visible on cp0_* until the next event
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_type <= EXC_NONE;
      lat_pc   <= '0;
      lat_bad  <= '0;
      lat_ds   <= 1'b0;
    end else if (accept) begin
      lat_type <= evt_code;
      lat_pc   <= bus.m_pc;
      lat_bad  <= evt_bad;
      lat_ds   <= bus.m_in_delayslot;
    end
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state and per-state strobes; ERET is the only event latched as EXC_NONE
  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    flush         = 1'b0;
    commit        = 1'b0;
    redirect      = 1'b0;
    redirect_addr = '0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = bus.mem_busy ? DRAIN : COMMIT;
      end
      DRAIN: begin
        stall = 1'b1;
        if (!bus.mem_busy) state_nxt = COMMIT;
      end
      COMMIT: begin
        stall     = 1'b1;
        commit    = 1'b1;
        state_nxt = FLUSH;
      end
      FLUSH: begin
        flush         = 1'b1;
        redirect      = 1'b1;
        redirect_addr = (lat_type == EXC_NONE) ? bus.cp0_epc : EXC_VECTOR;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.cp0_en           = commit;
  assign bus.cp0_except_type  = lat_type;
  assign bus.cp0_pc           = lat_pc;
  assign bus.cp0_in_delayslot = lat_ds;
  assign bus.cp0_badvaddr     = lat_bad;
  assign bus.hw_ip            = hw_ip;
  assign bus.stall_o          = stall;
  assign bus.flush_o          = flush;
  assign bus.redirect_valid   = redirect;
  assign bus.redirect_pc      = redirect_addr;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb/tb_exception_ctrl.sv - randomized and directed bench for exception_ctrl against a timeline model
module tb_exception_ctrl;
  localparam logic [31:0] VEC = 32'hBFC00380;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  exception_ctrl_if bus_if();

  exception_ctrl dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: one transaction on a cycle timeline ----------------
  // accept at cycle A; memory first seen idle at cycle I (I >= A); commit at I+1; flush at I+2
  bit          md_active = 0;
  int          md_accept = 0;
  int          md_idle = -1;
  int          cyc = 0;
  logic [4:0]  md_type = 5'h1F;
  logic [31:0] md_pc = 0;
  logic [31:0] md_bad = 0;
  logic        md_ds = 0;
  logic [5:0]  ext_d1 = 0;
  logic [5:0]  ext_d2 = 0;
  bit          was_idle;
  bit          hit;
  logic [4:0]  code;
  logic [31:0] bad;

  function automatic logic [5:0] model_hw();
    return {ext_d2[5] | bus_if.timer_interrupt, ext_d2[4:0]};
  endfunction

  function automatic void classify(output bit h, output logic [4:0] c, output logic [31:0] b);
    logic [7:0] ip;
    bit         pend;
    bit         f[9];
    logic [4:0] cs[9];
    ip   = (bus_if.cp0_cause[15:8] | {model_hw(), 2'b00}) & bus_if.cp0_status[15:8];
    pend = (ip != 8'h00) && bus_if.cp0_status[0] && !bus_if.cp0_status[1];
    f    = '{pend, bus_if.m_adel_if, bus_if.m_ri, bus_if.m_ov, bus_if.m_sys,
             bus_if.m_bp, bus_if.m_adel_d, bus_if.m_ades_d, bus_if.m_eret};
    cs   = '{5'h00, 5'h04, 5'h0A, 5'h0C, 5'h08, 5'h09, 5'h04, 5'h05, 5'h1F};
    h = 0; c = 5'h1F; b = 32'h0;
    for (int i = 0; i < 9; i++) begin
      if (f[i] && !h) begin
        h = 1;
        c = cs[i];
        if (i == 1) b = bus_if.m_pc;
        else if (i == 6 || i == 7) b = bus_if.m_data_addr;
      end
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_active = 0; md_idle = -1; cyc = 0;
      md_type = 5'h1F; md_pc = 0; md_bad = 0; md_ds = 0;
      ext_d1 = 0; ext_d2 = 0;
    end else begin
      was_idle = !md_active;
      if (md_active && md_idle >= 0 && cyc == md_idle + 2) md_active = 0;
      classify(hit, code, bad);
      if (was_idle && bus_if.m_valid && hit) begin
        md_active = 1; md_accept = cyc; md_idle = -1;
        md_type = code; md_bad = bad; md_pc = bus_if.m_pc; md_ds = bus_if.m_in_delayslot;
      end
      if (md_active && md_idle < 0 && !bus_if.mem_busy) md_idle = cyc;
      ext_d2 = ext_d1;
      ext_d1 = bus_if.ext_int;
      cyc++;
    end
  end

  // compare DUT against the model every cycle, away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      logic exp_en, exp_fl, exp_st;
      logic [31:0] exp_rpc;
      exp_en  = md_active && md_idle >= 0 && cyc == md_idle + 1;
      exp_fl  = md_active && md_idle >= 0 && cyc == md_idle + 2;
      exp_st  = md_active && cyc > md_accept && (md_idle < 0 || cyc == md_idle + 1);
      exp_rpc = exp_fl ? ((md_type == 5'h1F) ? bus_if.cp0_epc : VEC) : 32'h0;
      chk("m_cp0_en",   bus_if.cp0_en, exp_en);
      chk("m_flush",    bus_if.flush_o, exp_fl);
      chk("m_redir_v",  bus_if.redirect_valid, exp_fl);
      chk("m_stall",    bus_if.stall_o, exp_st);
      chk("m_redir_pc", bus_if.redirect_pc, exp_rpc);
      chk("m_type",     bus_if.cp0_except_type, md_type);
      chk("m_pc",       bus_if.cp0_pc, md_pc);
      chk("m_ds",       bus_if.cp0_in_delayslot, md_ds);
      chk("m_bad",      bus_if.cp0_badvaddr, md_bad);
      chk("m_hw_ip",    bus_if.hw_ip, model_hw());
    end
  end

  // ---------------- stimulus ----------------
  task automatic clear_evt();
    bus_if.m_valid = 0; bus_if.m_adel_if = 0; bus_if.m_ri = 0; bus_if.m_ov = 0;
    bus_if.m_sys = 0; bus_if.m_bp = 0; bus_if.m_adel_d = 0; bus_if.m_ades_d = 0;
    bus_if.m_eret = 0; bus_if.m_in_delayslot = 0;
  endtask

  task automatic idle_inputs();
    clear_evt();
    bus_if.m_pc = 0; bus_if.m_data_addr = 0; bus_if.mem_busy = 0; bus_if.ext_int = 0;
    bus_if.timer_interrupt = 0; bus_if.cp0_status = 0; bus_if.cp0_cause = 0; bus_if.cp0_epc = 0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // event already driven at posedge+2 (cycle N), memory idle: commit at N+1, flush at N+2
  task automatic fire(input string nm, input logic [4:0] c, input logic [31:0] pc,
                      input logic ds, input logic [31:0] b, input logic [31:0] rpc);
    @(negedge clk);
    chk({nm, "_n_en"}, bus_if.cp0_en, 0);
    chk({nm, "_n_stall"}, bus_if.stall_o, 0);
    @(posedge clk); #2; clear_evt();
    @(negedge clk);
    chk({nm, "_en"}, bus_if.cp0_en, 1);
    chk({nm, "_stall"}, bus_if.stall_o, 1);
    chk({nm, "_type"}, bus_if.cp0_except_type, c);
    chk({nm, "_pc"}, bus_if.cp0_pc, pc);
    chk({nm, "_ds"}, bus_if.cp0_in_delayslot, ds);
    chk({nm, "_bad"}, bus_if.cp0_badvaddr, b);
    @(negedge clk);
    chk({nm, "_flush"}, bus_if.flush_o, 1);
    chk({nm, "_redir_v"}, bus_if.redirect_valid, 1);
    chk({nm, "_redir_pc"}, bus_if.redirect_pc, rpc);
    chk({nm, "_fl_stall"}, bus_if.stall_o, 0);
    chk({nm, "_fl_en"}, bus_if.cp0_en, 0);
    @(posedge clk); #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1;
    @(posedge clk); #2;
    chk("rst_en", bus_if.cp0_en, 0);
    chk("rst_type", bus_if.cp0_except_type, 5'h1F);
    chk("rst_pc", bus_if.cp0_pc, 0);
    chk("rst_bad", bus_if.cp0_badvaddr, 0);
    chk("rst_stall", bus_if.stall_o, 0);
    chk("rst_flush", bus_if.flush_o, 0);
    chk("rst_redir", bus_if.redirect_valid, 0);
    chk("rst_hw_ip", bus_if.hw_ip, 0);
    step(1);
    rst = 0;
    step(2);

    // overflow
    bus_if.m_valid = 1; bus_if.m_ov = 1; bus_if.m_pc = 32'hBFC00100;
    fire("ov", 5'h0C, 32'hBFC00100, 0, 0, VEC);
    @(negedge clk);
    chk("ov_after_flush", bus_if.flush_o, 0);
    step(1);

    // store address error with three busy cycles
    bus_if.m_valid = 1; bus_if.m_ades_d = 1; bus_if.m_pc = 32'hBFC00120;
    bus_if.m_data_addr = 32'h80000003; bus_if.mem_busy = 1;
    step(1); clear_evt();
    @(negedge clk); chk("ades_d1_stall", bus_if.stall_o, 1); chk("ades_d1_en", bus_if.cp0_en, 0);
    step(1);
    @(negedge clk); chk("ades_d2_stall", bus_if.stall_o, 1); chk("ades_d2_en", bus_if.cp0_en, 0);
    step(1); bus_if.mem_busy = 0;
    @(negedge clk); chk("ades_d3_stall", bus_if.stall_o, 1); chk("ades_d3_en", bus_if.cp0_en, 0);
    @(negedge clk);
    chk("ades_en", bus_if.cp0_en, 1);
    chk("ades_type", bus_if.cp0_except_type, 5'h05);
    chk("ades_bad", bus_if.cp0_badvaddr, 32'h80000003);
    @(negedge clk); chk("ades_flush", bus_if.flush_o, 1);
    step(1);

    // simultaneous exceptions: RI wins
    bus_if.m_valid = 1; bus_if.m_ri = 1; bus_if.m_sys = 1; bus_if.m_adel_d = 1;
    bus_if.m_pc = 32'hBFC00140; bus_if.m_data_addr = 32'h00001235;
    fire("multi", 5'h0A, 32'hBFC00140, 0, 0, VEC);

    // same stimulus with a pending interrupt: interrupt wins
    bus_if.cp0_status = 32'h00000401; bus_if.ext_int = 6'h01;
    step(3);
    bus_if.m_valid = 1; bus_if.m_ri = 1; bus_if.m_sys = 1; bus_if.m_adel_d = 1;
    bus_if.m_pc = 32'hBFC00160;
    fire("multi_int", 5'h00, 32'hBFC00160, 0, 0, VEC);
    bus_if.ext_int = 0; bus_if.cp0_status = 0;
    step(3);

    // interrupt gating by EXL and IE, then taken once unmasked
    bus_if.ext_int = 6'h01; bus_if.cp0_status = 32'h00000403;
    bus_if.m_valid = 1; bus_if.m_pc = 32'hBFC00180;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("gate_exl_en", bus_if.cp0_en, 0);
    end
    step(1); bus_if.cp0_status = 32'h00000400;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("gate_ie_en", bus_if.cp0_en, 0);
    end
    step(1); bus_if.cp0_status = 32'h00000401;
    fire("gate_open", 5'h00, 32'hBFC00180, 0, 0, VEC);
    bus_if.ext_int = 0; bus_if.cp0_status = 0;
    step(3);

    // ERET in a delay slot
    bus_if.cp0_epc = 32'hBFC00200;
    bus_if.m_valid = 1; bus_if.m_eret = 1; bus_if.m_in_delayslot = 1; bus_if.m_pc = 32'hBFC001A0;
    fire("eret", 5'h1F, 32'hBFC001A0, 1, 0, 32'hBFC00200);

    // reset during COMMIT
    bus_if.m_valid = 1; bus_if.m_bp = 1; bus_if.m_pc = 32'hBFC001C0;
    step(1); clear_evt();
    #2; rst = 1; #1;
    chk("rstc_en", bus_if.cp0_en, 0);
    chk("rstc_stall", bus_if.stall_o, 0);
    chk("rstc_type", bus_if.cp0_except_type, 5'h1F);
    step(1); rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rstc_no_flush", bus_if.flush_o, 0); chk("rstc_no_en", bus_if.cp0_en, 0);
    end
    step(1);

    // reset during DRAIN
    bus_if.m_valid = 1; bus_if.m_sys = 1; bus_if.mem_busy = 1;
    step(1); clear_evt();
    #2; rst = 1; #1;
    chk("rstd_stall", bus_if.stall_o, 0);
    chk("rstd_pc", bus_if.cp0_pc, 0);
    step(1); rst = 0; bus_if.mem_busy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("rstd_no_en", bus_if.cp0_en, 0); chk("rstd_no_flush", bus_if.flush_o, 0);
    end
    step(1);

    // randomized traffic checked against the model
    for (int i = 0; i < 600; i++) begin
      bus_if.m_valid        = ($urandom_range(0, 3) != 0);
      bus_if.m_adel_if      = ($urandom_range(0, 15) == 0);
      bus_if.m_ri           = ($urandom_range(0, 15) == 0);
      bus_if.m_ov           = ($urandom_range(0, 15) == 0);
      bus_if.m_sys          = ($urandom_range(0, 15) == 0);
      bus_if.m_bp           = ($urandom_range(0, 15) == 0);
      bus_if.m_adel_d       = ($urandom_range(0, 15) == 0);
      bus_if.m_ades_d       = ($urandom_range(0, 15) == 0);
      bus_if.m_eret         = ($urandom_range(0, 15) == 0);
      bus_if.m_in_delayslot = $urandom_range(0, 1);
      bus_if.m_pc           = $urandom;
      bus_if.m_data_addr    = $urandom;
      bus_if.mem_busy       = ($urandom_range(0, 2) == 0);
      bus_if.timer_interrupt = ($urandom_range(0, 31) == 0);
      bus_if.cp0_cause      = ($urandom_range(0, 31) == 0) ? 32'h00000100 : 32'h0;
      if ($urandom_range(0, 15) == 0) bus_if.ext_int = 6'($urandom);
      if ($urandom_range(0, 7) == 0) bus_if.cp0_epc = $urandom;
      if ($urandom_range(0, 31) == 0) begin
        case ($urandom_range(0, 4))
          0: bus_if.cp0_status = 32'h00000000;
          1: bus_if.cp0_status = 32'h00000401;
          2: bus_if.cp0_status = 32'h0000FF03;
          3: bus_if.cp0_status = 32'h0000FF01;
          default: bus_if.cp0_status = 32'h00008101;
        endcase
      end
      step(1);
    end

    idle_inputs();
    step(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
Name: exception_ctrl

Overview:
- Sequences CP0 on precise exceptions, interrupts and ERET.
- Watches the instruction in the M stage and picks the highest-priority event.
- Waits for outstanding SRAM data accesses to drain, then pulses the CP0 commit (en/except_type/epc/badvaddr inputs).
- Flushes the pipeline and redirects fetch to the exception vector or to EPC.
- Sits between the M-stage pipeline registers, the CP0 register file and the PC/hazard unit.

Parameters:
EXC_VECTOR, 32'hBFC00380, fetch redirect target for all exceptions and interrupts.
EXC_NONE, 5'b11111, except_type code meaning "no exception" (selects the CP0 EXL-clear path on ERET).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
m_valid  in  1  M stage holds a real (non-bubble) instruction
m_pc  in  32  PC of M-stage instruction
m_in_delayslot  in  1  M instruction is in a branch delay slot
m_adel_if  in  1  fetch address error
m_ri  in  1  reserved instruction
m_ov  in  1  arithmetic overflow
m_sys  in  1  syscall
m_bp  in  1  break
m_adel_d  in  1  load address error
m_ades_d  in  1  store address error
m_data_addr  in  32  load/store effective address
m_eret  in  1  ERET in M
mem_busy  in  1  SRAM data access outstanding
ext_int  in  6  asynchronous hardware interrupt lines
timer_interrupt  in  1  CP0 timer interrupt
cp0_status  in  32  CP0 Status
cp0_cause  in  32  CP0 Cause
cp0_epc  in  32  CP0 EPC
cp0_en  out  1  CP0 commit strobe
cp0_except_type  out  5  exception code for CP0
cp0_pc  out  32  current_inst_addr to CP0
cp0_in_delayslot  out  1  is_in_delayslot to CP0
cp0_badvaddr  out  32  badvaddr_i to CP0
hw_ip  out  6  synchronized interrupt pending bits, IP[7:2]
stall_o  out  1  freeze IF..M
flush_o  out  1  kill IF..M
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  32  new fetch address

Behaviour:
- Reset (async): state=IDLE; all outputs 0; except_type=EXC_NONE; synchronizers and latches 0.
- ext_int passes through a 2-flop synchronizer. hw_ip = {sync[5] | timer_interrupt, sync[4:0]}.
- int_pend = |((cp0_cause[15:8] | {hw_ip,2'b00}) & cp0_status[15:8]) & cp0_status[0] & ~cp0_status[1].
- Priority, high to low: INT > ADEL_IF > RI > OV > SYS > BP > ADEL_D > ADES_D > ERET.
- Codes: INT 0x00, ADEL 0x04, ADES 0x05, SYS 0x08, BP 0x09, RI 0x0A, OV 0x0C, ERET EXC_NONE.
- badvaddr latch: m_pc for ADEL_IF, m_data_addr for ADEL_D/ADES_D, else 0.
- An event is accepted only in IDLE with m_valid=1. Events in other states are ignored; the pipeline is stalled, so the instruction is held.
- FSM:
  - IDLE: on event, latch code, pc, delayslot and badvaddr. If mem_busy go DRAIN, else go COMMIT. stall_o=0.
  - DRAIN: stall_o=1. When mem_busy=0 go COMMIT. No timeout.
  - COMMIT: stall_o=1, cp0_en=1 for exactly one cycle with latched values on the cp0_* outputs. Go FLUSH.
  - FLUSH: stall_o=0, flush_o=1, redirect_valid=1 for one cycle. redirect_pc = EXC_VECTOR, or cp0_epc for ERET (EPC is stable after COMMIT). Go IDLE.
- Latency without drain: event seen at cycle N, cp0_en at N+1, flush/redirect at N+2. Each drain cycle adds one.
- cp0_* outputs hold their latched values outside COMMIT, but cp0_en=0 there.
- Interrupt with exception on the same instruction: interrupt wins, EPC = m_pc (adjusted by CP0 for delay slot).
- ERET in a delay slot: treated as normal ERET; m_in_delayslot is passed through.
- Reset asserted mid-sequence: immediate return to IDLE, no partial commit or flush pulse.
- Back-to-back events: a new event can be accepted in the cycle after FLUSH.

Test Plan:
- Overflow: m_valid=1, m_ov=1, m_pc=0xBFC00100, mem_busy=0 -> cp0_en pulse at N+1 with type 0x0C, pc 0xBFC00100; flush_o/redirect_valid at N+2 with redirect_pc=0xBFC00380; stall_o high only at N+1.
- Store address error with drain: m_ades_d=1, m_data_addr=0x80000003, mem_busy high 3 cycles -> DRAIN for 3 cycles with stall_o=1; then cp0_en with type 0x05, badvaddr 0x80000003.
- Simultaneous events: m_ri=1, m_sys=1, m_adel_d=1 -> type 0x0A. Same stimulus plus int_pend (status=0x00000401, ext_int[0]=1 for ≥2 cycles) -> type 0x00.
- Interrupt gating: status EXL=1 or IE=0 with ext_int active -> no cp0_en. Clear EXL -> interrupt taken on next valid instruction.
- ERET: cp0_epc=0xBFC00200, m_eret=1 -> cp0_en with type 0x1F, then redirect_pc=0xBFC00200.
- Reset in COMMIT/DRAIN: rst asserted asynchronously -> all outputs 0 immediately, state IDLE; no flush after release.
